axis_rle_encoder: RTL

//  Run-length encoder for 128-bit AXI4-Stream sample words; sits directly upstream of the RLE interpreter.

---
 rtl/axis_rle_encoder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/axis_rle_encoder.sv
// axis_rle_encoder: run-length encoder for AXI4-Stream sample words.
// Consecutive identical words are merged. The count field is ignored when
// words are compared. It is overwritten with repeat = run_length - 1 on output.
// Optional feature macro: RLE_TIMEOUT_EN. When it is defined, an idle counter
// flushes a pending run after TIMEOUT_CYCLES cycles with no accepted input.
module axis_rle_encoder #(
  parameter int AXIS_TDATA_WIDTH = 128,
  parameter int RUN_MAX          = 65535,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        s_axis_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  output logic                        s_axis_tready,
  output logic                        m_axis_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  input  logic                        m_axis_tready,
  input  logic                        flush,
  output logic                        busy
);

  localparam int W       = AXIS_TDATA_WIDTH;
  localparam int CNT_MSB = W - 17;
  localparam logic [15:0] RUN_LIMIT = 16'(RUN_MAX);
  localparam logic [W-1:0] CNT_FIELD = {16'h0000, 16'hFFFF, {(W - 32){1'b0}}};

  // Reject configurations the count field cannot represent.
  if (W < 32 || RUN_MAX < 1 || RUN_MAX > 65535 || TIMEOUT_CYCLES < 1 ||
      TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("axis_rle_encoder: parameter out of range");
  end

  logic          hold_valid_q, hold_valid_d;
  logic [W-1:0]  hold_data_q,  hold_data_d;
  logic [15:0]   run_cnt_q,    run_cnt_d;
  logic          flush_pend_q, flush_pend_d;
  logic          out_valid_q,  out_valid_d;
  logic [W-1:0]  out_data_q,   out_data_d;

  logic out_free;
  logic accept;
  logic match;
  logic timeout_hit;

  assign out_free      = !out_valid_q | m_axis_tready;
  assign s_axis_tready = aresetn & !flush_pend_q & (!hold_valid_q | out_free);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign match         = ((s_axis_tdata ^ hold_data_q) & ~CNT_FIELD) == '0;

  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign busy          = hold_valid_q | out_valid_q | flush_pend_q;

`ifdef RLE_TIMEOUT_EN
  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] idle_q, idle_d;

  // Idle counter: it runs only while a run is held and no beat arrives.
  always_comb begin
    idle_d      = 16'd0;
    timeout_hit = 1'b0;
    if (hold_valid_q && !accept) begin
      if (idle_q == IDLE_LAST) begin
        timeout_hit = 1'b1;
      end else begin
        idle_d = idle_q + 16'd1;
      end
    end
  end

  // Idle counter register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) idle_q <= 16'd0;
    else          idle_q <= idle_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic for the run holder, the flush request and the output register.
  always_comb begin
    // NOTE: every signal gets a default here, so no path can leave a latch behind.
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    run_cnt_d    = run_cnt_q;
    flush_pend_d = flush_pend_q;
    out_valid_d  = out_valid_q & !m_axis_tready;
    out_data_d   = out_data_q;

    if (accept) begin
      if (hold_valid_q && match && (run_cnt_q < RUN_LIMIT)) begin
        run_cnt_d = run_cnt_q + 16'd1;
      end else begin
        // A mismatch or a saturated run closes the held run. Accepting the
        // beat already required out_free, so the output register can load it.
        if (hold_valid_q) begin
          out_valid_d                    = 1'b1;
          out_data_d                     = hold_data_q;
          out_data_d[CNT_MSB -: 16]      = run_cnt_q;
        end
        hold_valid_d = 1'b1;
        hold_data_d  = s_axis_tdata;
        run_cnt_d    = 16'd0;
      end
    end else if (flush_pend_q) begin
      // tready is low while a flush is pending, so no beat can compete here.
      if (!hold_valid_q) begin
        flush_pend_d = 1'b0;
      end else if (out_free) begin
        out_valid_d               = 1'b1;
        out_data_d                = hold_data_q;
        out_data_d[CNT_MSB -: 16] = run_cnt_q;
        hold_valid_d              = 1'b0;
        flush_pend_d              = 1'b0;
      end
    end

    // A beat that arrives together with the flush pulse joins the run first.
    // The flush is then serviced on a later cycle.
    if (flush || timeout_hit) flush_pend_d = 1'b1;
  end

  // State registers. Every register, including the data registers, clears on reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      run_cnt_q    <= 16'd0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      run_cnt_q    <= run_cnt_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

endmodule
